bram_arbiter: RTL and testbench

- Shares the single-port 64 KiByte main-memory BRAM (32-bit words, 1-cycle read latency) between two bus masters.
- m0 is the pipeline data/instruction port; m1 is a secondary master (UART boot loader DMA, debug).
- Fixed priority to m0, with a starvation guard that forces a grant to m1 after a bounded wait.
- Sits between the masters and the BRAM memory instance in the board top level.

---
 rtl/bram_arbiter.sv | 92 +++++++++
 tb/tb_bram_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - two-master single-port BRAM arbiter, m0 priority with m1 starvation guard
// Optional ARB_STATS_EN builds the 32-bit conflict counter; otherwise stat_conflicts is tied to 0.
module bram_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_write,
  input  logic [3:0]            m0_wmask,
  input  logic [31:0]           m0_wdata,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  input  logic                  m1_req,
  input  logic                  m1_write,
  input  logic [3:0]            m1_wmask,
  input  logic [31:0]           m1_wdata,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [31:0]           rdata,
  output logic                  mem_write,
  output logic [3:0]            mem_wmask,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           stat_conflicts
);

  localparam int WAIT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic force_m1;

  generate
    if (STARVE_LIMIT != 0) begin : g_starve
      logic [WAIT_W-1:0] wait_cnt;

      // Saturation is implicit: reaching the limit forces a grant, which clears the count.
      always_ff @(posedge clk) begin
        if (rst || !m1_req || m1_gnt) begin
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end

      assign force_m1 = (wait_cnt == WAIT_W'(STARVE_LIMIT));
    end else begin : g_no_starve
      assign force_m1 = 1'b0;
    end
  endgenerate

  assign m1_gnt = !rst && m1_req && (!m0_req || force_m1);
  assign m0_gnt = !rst && m0_req && !m1_gnt;

  // m0 owns the memory bus whenever m1 is not granted, so idle cycles keep m0's address stable.
  assign mem_addr  = m1_gnt ? m1_addr  : m0_addr;
  assign mem_wdata = m1_gnt ? m1_wdata : m0_wdata;
  assign mem_wmask = m1_gnt ? m1_wmask : m0_wmask;
  assign mem_write = (m0_gnt && m0_write) || (m1_gnt && m1_write);

  always_ff @(posedge clk) begin
    if (rst) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_rvalid <= m0_gnt && !m0_write;
      m1_rvalid <= m1_gnt && !m1_write;
    end
  end

  assign rdata = mem_rdata;

`ifdef ARB_STATS_EN
  logic [31:0] conflict_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (m0_req && m1_req) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

  assign stat_conflicts = conflict_cnt;
`else
  assign stat_conflicts = 32'd0;
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - randomized self-checking bench for bram_arbiter
module tb_bram_arbiter;
  localparam int AW    = 14;
  localparam int LIMIT = 8;
`ifdef ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          m0_req, m0_write, m1_req, m1_write;
  logic [3:0]    m0_wmask, m1_wmask;
  logic [31:0]   m0_wdata, m1_wdata;
  logic [AW-1:0] m0_addr, m1_addr;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0]   rdata, mem_wdata, mem_rdata, stat_conflicts;
  logic          mem_write;
  logic [3:0]    mem_wmask;
  logic [AW-1:0] mem_addr;

  logic          fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid, fp_mem_write;
  logic [31:0]   fp_rdata, fp_mem_wdata, fp_stat;
  logic [3:0]    fp_mem_wmask;
  logic [AW-1:0] fp_mem_addr;

  int tests_run = 0;
  int tests_failed = 0;

  bram_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_write(m0_write), .m0_wmask(m0_wmask), .m0_wdata(m0_wdata), .m0_addr(m0_addr),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_write(m1_write), .m1_wmask(m1_wmask), .m1_wdata(m1_wdata), .m1_addr(m1_addr),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .rdata(rdata), .mem_write(mem_write), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .stat_conflicts(stat_conflicts)
  );

  // Pure fixed-priority build sharing the same stimulus.
  bram_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(0)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_write(m0_write), .m0_wmask(m0_wmask), .m0_wdata(m0_wdata), .m0_addr(m0_addr),
    .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid),
    .m1_req(m1_req), .m1_write(m1_write), .m1_wmask(m1_wmask), .m1_wdata(m1_wdata), .m1_addr(m1_addr),
    .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid),
    .rdata(fp_rdata), .mem_write(fp_mem_write), .mem_wmask(fp_mem_wmask), .mem_wdata(fp_mem_wdata),
    .mem_addr(fp_mem_addr), .mem_rdata(mem_rdata), .stat_conflicts(fp_stat)
  );

  function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
    logic [31:0] bits;
    bits = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (old & ~bits) | (nw & bits);
  endfunction

  // Read-first BRAM with a bench-only preload port.
  logic [31:0]   bram    [0:(1<<AW)-1];
  logic [31:0]   ref_mem [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [31:0]   pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) bram[pl_addr] <= pl_data;
    else if (mem_write) bram[mem_addr] <= wmerge(bram[mem_addr], mem_wdata, mem_wmask);
    mem_rdata <= bram[mem_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    m0_req = 0; m0_write = 0; m0_wmask = 4'hF; m0_wdata = '0; m0_addr = '0;
    m1_req = 0; m1_write = 0; m1_wmask = 4'hF; m1_wdata = '0; m1_addr = '0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    pl_en = 1; pl_addr = a; pl_data = d; ref_mem[a] = d;
    tick;
    pl_en = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    m0_req = 1; m0_write = 1; m1_req = 1; m1_write = 1;
    #3;
    tests_run++; if ({m0_gnt, m1_gnt} !== 2'b00) begin tests_failed++; $display("FAIL reset_gnt: got %b want 00", {m0_gnt, m1_gnt}); end
    tests_run++; if ({mem_write, fp_mem_write} !== 2'b00) begin tests_failed++; $display("FAIL reset_mem_write: got %b want 00", {mem_write, fp_mem_write}); end
    tick;
    tests_run++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin tests_failed++; $display("FAIL reset_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); end
    tests_run++; if (stat_conflicts !== 32'd0) begin tests_failed++; $display("FAIL reset_stat: got %0d want 0", stat_conflicts); end
    idle;
    tick;
    rst = 0;
  endtask

  task automatic test_single_read;
    idle;
    m0_req = 1; m0_addr = 14'h3F80;
    #3;
    tests_run++; if ({m0_gnt, m1_gnt} !== 2'b10) begin tests_failed++; $display("FAIL single_read_gnt: got %b want 10", {m0_gnt, m1_gnt}); end
    tests_run++; if (mem_addr !== 14'h3F80) begin tests_failed++; $display("FAIL single_read_addr: got %h want 3f80", mem_addr); end
    tick;
    idle;
    #3;
    tests_run++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin tests_failed++; $display("FAIL single_read_rvalid: got %b want 10", {m0_rvalid, m1_rvalid}); end
    tests_run++; if (rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL single_read_rdata: got %h want deadbeef", rdata); end
    tick;
  endtask

  task automatic test_masked_write;
    logic [31:0] want;
    want = wmerge(ref_mem[14'h0010], 32'h12345678, 4'b0011);
    idle;
    m1_req = 1; m1_write = 1; m1_wmask = 4'b0011; m1_wdata = 32'h12345678; m1_addr = 14'h0010;
    #3;
    tests_run++; if ({m0_gnt, m1_gnt, mem_write} !== 3'b011) begin tests_failed++; $display("FAIL mwrite_gnt: got %b want 011", {m0_gnt, m1_gnt, mem_write}); end
    tests_run++; if (mem_wmask !== 4'b0011) begin tests_failed++; $display("FAIL mwrite_mask: got %b want 0011", mem_wmask); end
    ref_mem[14'h0010] = want;
    tick;
    idle;
    m0_req = 1; m0_addr = 14'h0010;
    #3;
    tests_run++; if ({m0_gnt, m1_rvalid} !== 2'b10) begin tests_failed++; $display("FAIL mwrite_read_gnt: got %b want 10", {m0_gnt, m1_rvalid}); end
    tick;
    idle;
    #3;
    tests_run++; if (m0_rvalid !== 1'b1) begin tests_failed++; $display("FAIL mwrite_rvalid: got %b want 1", m0_rvalid); end
    tests_run++; if (rdata !== 32'hAAAA5678) begin tests_failed++; $display("FAIL mwrite_rdata: got %h want aaaa5678 (model %h)", rdata, want); end
    tick;
  endtask

  task automatic test_starvation;
    int  m1_grants;
    logic prev_m1;
    m1_grants = 0; prev_m1 = 0;
    idle;
    tick;
    m1_req = 1; m1_addr = 14'd5;
    for (int i = 0; i < 20; i++) begin
      logic exp_m1;
      m0_req = 1; m0_addr = AW'(i % 16);
      exp_m1 = ((i % (LIMIT + 1)) == LIMIT);
      #3;
      tests_run++; if ({m0_gnt, m1_gnt} !== {!exp_m1, exp_m1}) begin tests_failed++; $display("FAIL starve_gnt[%0d]: got %b want %b", i, {m0_gnt, m1_gnt}, {!exp_m1, exp_m1}); end
      tests_run++; if ({fp_m0_gnt, fp_m1_gnt} !== 2'b10) begin tests_failed++; $display("FAIL fixed_prio_gnt[%0d]: got %b want 10", i, {fp_m0_gnt, fp_m1_gnt}); end
      if (i > 0) begin
        tests_run++; if (m1_rvalid !== prev_m1) begin tests_failed++; $display("FAIL starve_rvalid[%0d]: got %b want %b", i, m1_rvalid, prev_m1); end
      end
      if (m1_gnt === 1'b1) m1_grants++;
      prev_m1 = exp_m1;
      tick;
    end
    tests_run++; if (m1_grants != 2) begin tests_failed++; $display("FAIL starve_count: got %0d want 2", m1_grants); end
    idle;
    tick;
  endtask

  task automatic test_reset_mid;
    idle;
    m0_req = 1; m0_addr = 14'd3;
    #3;
    tests_run++; if (m0_gnt !== 1'b1) begin tests_failed++; $display("FAIL rmid_gnt: got %b want 1", m0_gnt); end
    tick;
    rst = 1; m1_req = 1; m1_addr = 14'd4;
    #3;
    tests_run++; if ({m0_gnt, m1_gnt, fp_m0_gnt, fp_m1_gnt} !== 4'b0000) begin tests_failed++; $display("FAIL rmid_gnt_in_rst: got %b want 0000", {m0_gnt, m1_gnt, fp_m0_gnt, fp_m1_gnt}); end
    tick;
    rst = 0; m1_req = 0;
    #3;
    tests_run++; if ({m0_rvalid, m0_gnt} !== 2'b01) begin tests_failed++; $display("FAIL rmid_after: got rvalid,gnt=%b want 01", {m0_rvalid, m0_gnt}); end
    tick;
    idle;
    #3;
    tests_run++; if ({m0_rvalid, rdata} !== {1'b1, ref_mem[3]}) begin tests_failed++; $display("FAIL rmid_resume: got %b/%h want 1/%h", m0_rvalid, rdata, ref_mem[3]); end
    tick;
    // Reset must also discard the accumulated m1 wait.
    m0_req = 1; m1_req = 1; m1_addr = 14'd6;
    repeat (5) tick;
    rst = 1;
    tick;
    rst = 0;
    for (int i = 0; i <= LIMIT; i++) begin
      #3;
      tests_run++; if (m1_gnt !== (i == LIMIT)) begin tests_failed++; $display("FAIL rmid_wait_clear[%0d]: got %b want %b", i, m1_gnt, (i == LIMIT)); end
      tick;
    end
    idle;
    tick;
  endtask

  task automatic test_stats;
    idle;
    rst = 1;
    tick;
    rst = 0;
    m0_req = 1; m1_req = 1; m1_addr = 14'd7;
    repeat (5) tick;
    m1_req = 0;
    repeat (3) tick;
    idle;
    #3;
    tests_run++; if (stat_conflicts !== (STATS ? 32'd5 : 32'd0)) begin tests_failed++; $display("FAIL stats: got %0d want %0d", stat_conflicts, STATS ? 5 : 0); end
    tick;
  endtask

  task automatic test_random;
    logic        g0, g1, e0, e1, rv0, rv1, n_rv0, n_rv1, e_mw;
    logic [31:0] rd0, rd1;
    int          streak, conf;
    idle;
    rst = 1;
    tick;
    rst = 0;
    g0 = 1; g1 = 1; rv0 = 0; rv1 = 0; rd0 = '0; rd1 = '0; streak = 0; conf = 0;
    for (int c = 0; c < 400; c++) begin
      // A master whose request was not yet accepted keeps it unchanged.
      if (!m0_req || g0) begin
        m0_req = ($urandom_range(0, 2) != 0); m0_write = 1'($urandom_range(0, 1));
        m0_wmask = 4'($urandom_range(1, 15)); m0_wdata = $urandom; m0_addr = AW'($urandom_range(0, 15));
      end
      if (!m1_req || g1) begin
        m1_req = 1'($urandom_range(0, 1)); m1_write = 1'($urandom_range(0, 1));
        m1_wmask = 4'($urandom_range(1, 15)); m1_wdata = $urandom; m1_addr = AW'($urandom_range(0, 15));
      end
      rst = ($urandom_range(0, 39) == 0);
      e1 = !rst && m1_req && (!m0_req || streak == LIMIT);
      e0 = !rst && m0_req && !e1;
      e_mw = (e0 && m0_write) || (e1 && m1_write);
      #3;
      tests_run++; if ({m0_gnt, m1_gnt, mem_write} !== {e0, e1, e_mw}) begin tests_failed++; $display("FAIL rand_gnt[%0d]: got %b want %b", c, {m0_gnt, m1_gnt, mem_write}, {e0, e1, e_mw}); end
      tests_run++; if ({fp_m0_gnt, fp_m1_gnt} !== {!rst && m0_req, !rst && m1_req && !m0_req}) begin tests_failed++; $display("FAIL rand_fp_gnt[%0d]: got %b", c, {fp_m0_gnt, fp_m1_gnt}); end
      if (e0 || e1) begin
        tests_run++; if (mem_addr !== (e1 ? m1_addr : m0_addr)) begin tests_failed++; $display("FAIL rand_addr[%0d]: got %h want %h", c, mem_addr, e1 ? m1_addr : m0_addr); end
      end
      tests_run++; if ({m0_rvalid, m1_rvalid} !== {rv0, rv1}) begin tests_failed++; $display("FAIL rand_rvalid[%0d]: got %b want %b", c, {m0_rvalid, m1_rvalid}, {rv0, rv1}); end
      if (rv0 || rv1) begin
        tests_run++; if (rdata !== (rv0 ? rd0 : rd1)) begin tests_failed++; $display("FAIL rand_rdata[%0d]: got %h want %h", c, rdata, rv0 ? rd0 : rd1); end
      end
      n_rv0 = e0 && !m0_write; rd0 = ref_mem[m0_addr];
      n_rv1 = e1 && !m1_write; rd1 = ref_mem[m1_addr];
      if (e0 && m0_write) ref_mem[m0_addr] = wmerge(ref_mem[m0_addr], m0_wdata, m0_wmask);
      if (e1 && m1_write) ref_mem[m1_addr] = wmerge(ref_mem[m1_addr], m1_wdata, m1_wmask);
      rv0 = n_rv0; rv1 = n_rv1;
      streak = (rst || !m1_req || e1) ? 0 : streak + 1;
      if (rst) conf = 0;
      else if (m0_req && m1_req) conf++;
      g0 = e0; g1 = e1;
      tick;
    end
    rst = 0;
    idle;
    #3;
    tests_run++; if (stat_conflicts !== (STATS ? 32'(conf) : 32'd0)) begin tests_failed++; $display("FAIL rand_stats: got %0d want %0d", stat_conflicts, STATS ? conf : 0); end
    tick;
  endtask

  initial begin
    rst = 1;
    idle;
    tick;
    for (int i = 0; i < 16; i++) preload(AW'(i), $urandom);
    preload(14'h3F80, 32'hDEADBEEF);
    preload(14'h0010, 32'hAAAAAAAA);
    test_reset;
    test_single_read;
    test_masked_write;
    test_starvation;
    test_reset_mid;
    test_stats;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
